// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if
//   Bundles the writeback handshakes, the issue-stage hazard query and the
//   register-file write port that surround regfile_wb_arbiter.
//   slave  : the arbiter's view. It takes requests and drives the ready,
//            stall, write-port and scoreboard outputs.
//   master : the view of the execute, memory and issue stages. It drives
//            requests and watches the arbiter's outputs.
//   Signals:
//     alu_valid/alu_rd/alu_data -> alu_ready   ALU writeback handshake
//     mem_valid/mem_rd/mem_data -> mem_ready   load writeback handshake
//     issue_valid/rs1/rs2/rd/wr -> issue_stall hazard query from issue
//     rf_we/rf_addr/rf_wdata                   register file WE3/A3/WD3
//     pending                                  scoreboard bit vector
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;

    logic            mem_valid;
    logic [AW-1:0]   mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            mem_ready;

    logic            issue_valid;
    logic [AW-1:0]   issue_rs1;
    logic [AW-1:0]   issue_rs2;
    logic [AW-1:0]   issue_rd;
    logic            issue_wr;
    logic            issue_stall;

    logic            rf_we;
    logic [AW-1:0]   rf_addr;
    logic [XLEN-1:0] rf_wdata;
    logic [NREG-1:0] pending;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_wr,
        output issue_stall,
        output rf_we, rf_addr, rf_wdata, pending
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_wr,
        input  issue_stall,
        input  rf_we, rf_addr, rf_wdata, pending
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   The ALU and load writeback paths both need the register file's single
//   write port. This block shares that port between them with round-robin
//   arbitration and registers the winning write one cycle later. It also
//   keeps a per-register pending-write scoreboard, so the issue stage can
//   stall on RAW and WAW hazards.
//   Ports:
//     clk   : clock; all state updates on the rising edge
//     reset : asynchronous, active-high; clears all state at once
//     bus   : regfile_wb_arbiter_if.slave (handshakes, issue query,
//             register-file write port, scoreboard)
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_wb_arbiter_if.slave   bus
);
    localparam int AW = $clog2(NREG);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    src_e            last_grant_q, last_grant_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_addr_q, rf_addr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic [NREG-1:0] pending_q, pending_d;

    logic grant_alu, grant_mem, xfer;
    logic issue_fire;

    // A lone requester always wins. On a tie, the source that lost last time wins.
    always_comb begin
        grant_alu = bus.alu_valid && (!bus.mem_valid || (last_grant_q == SRC_MEM));
        grant_mem = bus.mem_valid && (!bus.alu_valid || (last_grant_q == SRC_ALU));
    end

    assign xfer          = grant_alu || grant_mem;
    assign bus.alu_ready = grant_alu;
    assign bus.mem_ready = grant_mem;

    // Write stage. The address and data hold while idle. A write to x0 still
    // completes its handshake but never raises the write enable.
    always_comb begin
        last_grant_d = last_grant_q;
        rf_we_d      = 1'b0;
        rf_addr_d    = rf_addr_q;
        rf_wdata_d   = rf_wdata_q;
        if (grant_alu) begin
            last_grant_d = SRC_ALU;
            rf_we_d      = (bus.alu_rd != '0);
            rf_addr_d    = bus.alu_rd;
            rf_wdata_d   = bus.alu_data;
        end else if (grant_mem) begin
            last_grant_d = SRC_MEM;
            rf_we_d      = (bus.mem_rd != '0);
            rf_addr_d    = bus.mem_rd;
            rf_wdata_d   = bus.mem_data;
        end
    end

    // Hazard check. pending[0] is held at zero, so x0 never stalls issue.
    assign bus.issue_stall = bus.issue_valid &&
                             (pending_q[bus.issue_rs1] || pending_q[bus.issue_rs2] ||
                              (bus.issue_wr && pending_q[bus.issue_rd]));

    assign issue_fire = bus.issue_valid && bus.issue_wr && !bus.issue_stall &&
                        (bus.issue_rd != '0);

    // The clear is applied before the set, so the set wins when both hit the
    // same index. The bit drops on the edge where the register file captures
    // the data, so a read in the following cycle sees the new value.
    always_comb begin
        pending_d = pending_q;
        if (rf_we_q)
            pending_d[rf_addr_q] = 1'b0;
        if (issue_fire)
            pending_d[bus.issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // Asynchronous reset clears everything, including a write already in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= SRC_MEM;
            rf_we_q      <= 1'b0;
            rf_addr_q    <= '0;
            rf_wdata_q   <= '0;
            pending_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_we_q      <= rf_we_d;
            rf_addr_q    <= rf_addr_d;
            rf_wdata_q   <= rf_wdata_d;
            pending_q    <= pending_d;
        end
    end

    // Registered outputs drive the register file's write port directly.
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_addr  = rf_addr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.pending  = pending_q;

    // With xfer unused, lint reports it. It names the transfer condition for
    // readers, so it is folded into a sink here to keep it visible.
    logic unused_ok;
    assign unused_ok = xfer;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    regfile_wb_arbiter_if #(.XLEN(32), .NREG(32)) bus ();

    regfile_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
        bus.issue_valid = 1'b0; bus.issue_rs1 = '0; bus.issue_rs2 = '0;
        bus.issue_rd = '0; bus.issue_wr = 1'b0;
    endtask

    // Leaves the bench at posedge+1 with reset released.
    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1;
        n_checks++;
        if (bus.rf_we !== 1'b0 || bus.rf_addr !== 5'd0 || bus.rf_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_wport: got we=%b addr=%0d data=%h expected 0/0/0",
                     bus.rf_we, bus.rf_addr, bus.rf_wdata);
        end
        n_checks++;
        if (bus.pending !== 32'd0 || bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0 ||
            bus.issue_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got pending=%h ar=%b mr=%b stall=%b expected 0",
                     bus.pending, bus.alu_ready, bus.mem_ready, bus.issue_stall);
        end
        do_reset();
    endtask

    task automatic test_alu_single();
        do_reset();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h0000000D;
        #1;
        n_checks++;
        if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_single_ready: got ar=%b mr=%b expected 1/0",
                     bus.alu_ready, bus.mem_ready);
        end
        step();
        bus.alu_valid = 1'b0;
        n_checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_addr !== 5'd5 || bus.rf_wdata !== 32'hD) begin
            n_fail++;
            $display("FAIL alu_single_write: got we=%b addr=%0d data=%h expected 1/5/0000000d",
                     bus.rf_we, bus.rf_addr, bus.rf_wdata);
        end
        step();
        n_checks++;
        if (bus.rf_we !== 1'b0 || bus.rf_addr !== 5'd5 || bus.rf_wdata !== 32'hD) begin
            n_fail++;
            $display("FAIL alu_single_idle: got we=%b addr=%0d data=%h expected 0/5/0000000d",
                     bus.rf_we, bus.rf_addr, bus.rf_wdata);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'hA1;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd2; bus.mem_data = 32'hB2;
        for (int i = 0; i < 4; i++) begin
            logic exp_alu;
            exp_alu = (i % 2 == 0);
            #1;
            n_checks++;
            if (bus.alu_ready !== exp_alu || bus.mem_ready !== !exp_alu) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got ar=%b mr=%b expected ar=%b mr=%b",
                         i, bus.alu_ready, bus.mem_ready, exp_alu, !exp_alu);
            end
            step();
            n_checks++;
            if (bus.rf_we !== 1'b1 || bus.rf_addr !== (exp_alu ? 5'd1 : 5'd2) ||
                bus.rf_wdata !== (exp_alu ? 32'hA1 : 32'hB2)) begin
                n_fail++;
                $display("FAIL rr_write[%0d]: got we=%b addr=%0d data=%h expected addr=%0d",
                         i, bus.rf_we, bus.rf_addr, bus.rf_wdata, exp_alu ? 1 : 2);
            end
        end
        idle_inputs();
    endtask

    task automatic test_raw_hazard();
        do_reset();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd10; bus.issue_wr = 1'b1;
        #1;
        n_checks++;
        if (bus.issue_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_first_issue: got stall=%b expected 0", bus.issue_stall);
        end
        step();
        bus.issue_rd = 5'd0; bus.issue_wr = 1'b0; bus.issue_rs1 = 5'd10;
        #1;
        n_checks++;
        if (bus.issue_stall !== 1'b1 || bus.pending !== 32'h0000_0400) begin
            n_fail++;
            $display("FAIL raw_stall: got stall=%b pending=%h expected 1/00000400",
                     bus.issue_stall, bus.pending);
        end
        step();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'h55;
        #1;
        n_checks++;
        if (bus.issue_stall !== 1'b1 || bus.alu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL raw_hold: got stall=%b ar=%b expected 1/1", bus.issue_stall, bus.alu_ready);
        end
        step();
        bus.alu_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_addr !== 5'd10 || bus.issue_stall !== 1'b1 ||
            bus.pending[10] !== 1'b1) begin
            n_fail++;
            $display("FAIL raw_commit: got we=%b addr=%0d stall=%b p10=%b expected 1/10/1/1",
                     bus.rf_we, bus.rf_addr, bus.issue_stall, bus.pending[10]);
        end
        step();
        n_checks++;
        if (bus.rf_we !== 1'b0 || bus.issue_stall !== 1'b0 || bus.pending !== 32'd0) begin
            n_fail++;
            $display("FAIL raw_release: got we=%b stall=%b pending=%h expected 0/0/0",
                     bus.rf_we, bus.issue_stall, bus.pending);
        end
        idle_inputs();
    endtask

    task automatic test_x0_write();
        do_reset();
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'hFFFF_FFFF;
        #1;
        n_checks++;
        if (bus.mem_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL x0_ready: got mr=%b expected 1", bus.mem_ready);
        end
        step();
        bus.mem_valid = 1'b0;
        n_checks++;
        if (bus.rf_we !== 1'b0 || bus.pending !== 32'd0 || bus.rf_wdata !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL x0_write: got we=%b pending=%h data=%h expected 0/0/ffffffff",
                     bus.rf_we, bus.pending, bus.rf_wdata);
        end
    endtask

    task automatic test_set_wins();
        // Writeback to x7 while it is not pending, so issue of rd=7 is not
        // stalled on the edge where the write commits.
        do_reset();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77;
        step();
        bus.alu_valid = 1'b0;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.issue_wr = 1'b1;
        #1;
        n_checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_addr !== 5'd7 || bus.issue_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL setwin_setup: got we=%b addr=%0d stall=%b expected 1/7/0",
                     bus.rf_we, bus.rf_addr, bus.issue_stall);
        end
        step();
        bus.issue_valid = 1'b0;
        n_checks++;
        if (bus.pending !== 32'h0000_0080) begin
            n_fail++;
            $display("FAIL setwin_pending: got pending=%h expected 00000080", bus.pending);
        end
        idle_inputs();
    endtask

    task automatic test_reset_midop();
        do_reset();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd10; bus.issue_wr = 1'b1;
        step();
        bus.issue_valid = 1'b0; bus.issue_wr = 1'b0; bus.issue_rd = '0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hCAFE_F00D;
        step();
        bus.alu_valid = 1'b0;
        n_checks++;
        if (bus.rf_we !== 1'b1 || bus.pending !== 32'h0000_0400) begin
            n_fail++;
            $display("FAIL midop_setup: got we=%b pending=%h expected 1/00000400",
                     bus.rf_we, bus.pending);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.rf_we !== 1'b0 || bus.pending !== 32'd0 || bus.rf_addr !== 5'd0 ||
            bus.rf_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL midop_async: got we=%b pending=%h addr=%0d data=%h expected all 0",
                     bus.rf_we, bus.pending, bus.rf_addr, bus.rf_wdata);
        end
        step();
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_alu_single();
        test_round_robin();
        test_raw_hazard();
        test_x0_write();
        test_set_wins();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
